// File: rtl/verify_checksum_if.sv
// ----------------------------------------------------------------------------
// verify_checksum_if
// Byte-stream and verdict bundle for the FIX checksum checker.
//   data_i / data_valid_i / start_i : inbound byte stream (driven by master)
//   done_o / pass_o / err_o         : one-cycle verdict pulse, pass flag, error code
//   recv_checksum_o                 : binary value of the received digits (low 8 bits)
//   calc_checksum_o                 : computed sum mod 256
// The master modport belongs to the byte source; the checker uses the slave modport.
// ----------------------------------------------------------------------------
interface verify_checksum_if;
    logic [7:0] data_i;
    logic       data_valid_i;
    logic       start_i;
    logic       done_o;
    logic       pass_o;
    logic [2:0] err_o;
    logic [7:0] recv_checksum_o;
    logic [7:0] calc_checksum_o;

    modport master (
        output data_i, data_valid_i, start_i,
        input  done_o, pass_o, err_o, recv_checksum_o, calc_checksum_o
    );

    modport slave (
        input  data_i, data_valid_i, start_i,
        output done_o, pass_o, err_o, recv_checksum_o, calc_checksum_o
    );
endinterface

// File: rtl/verify_checksum.sv
// ----------------------------------------------------------------------------
// verify_checksum
// Receive-side FIX checksum checker. Keeps a running mod-256 sum of the
// message, snapshots it at every SOH, recognises the "10=" trailer tag that
// follows an SOH, decodes the three ASCII digits and the closing SOH, and
// reports a verdict one cycle after the last accepted byte.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : verify_checksum_if.slave (byte stream in, verdict out)
// Error codes: 0 none, 1 mismatch, 2 non-digit, 3 value>255,
//              4 missing terminator SOH, 5 length overflow.
// ----------------------------------------------------------------------------
module verify_checksum #(
    parameter logic [7:0]  SOH       = 8'h01,
    parameter logic [15:0] MAX_BYTES = 16'd4096
) (
    input  logic              clk,
    input  logic              rst,
    verify_checksum_if.slave  bus
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_BODY    = 4'd1;
    localparam logic [3:0] S_SAW_SOH = 4'd2;
    localparam logic [3:0] S_SAW_1   = 4'd3;
    localparam logic [3:0] S_SAW_0   = 4'd4;
    localparam logic [3:0] S_DIG0    = 4'd5;
    localparam logic [3:0] S_DIG1    = 4'd6;
    localparam logic [3:0] S_DIG2    = 4'd7;
    localparam logic [3:0] S_TERM    = 4'd8;

    logic [3:0]  r_state;
    logic [7:0]  r_sum;
    logic [7:0]  r_snap;
    logic [15:0] r_len;
    logic [9:0]  r_val;
    logic        r_done;
    logic        r_pass;
    logic [2:0]  r_err;
    logic [7:0]  r_recv;
    logic [7:0]  r_calc;

    logic [7:0]  w_byte;
    logic        w_is_soh;
    logic        w_is_digit;
    logic        w_in_body;
    logic        w_len_over;
    logic [7:0]  w_sum_next;
    logic [9:0]  w_val_next;
    logic [2:0]  w_trailer_err;
    logic [3:0]  w_state_next;
    logic        w_finish;
    logic [2:0]  w_fin_err;

    assign w_byte     = bus.data_i;
    assign w_is_soh   = (w_byte == SOH);
    assign w_is_digit = (w_byte >= 8'h30) && (w_byte <= 8'h39);
    // Body-phase states where bytes feed the running sum and SOH snapshots.
    assign w_in_body  = (r_state == S_BODY) || (r_state == S_SAW_SOH) ||
                        (r_state == S_SAW_1) || (r_state == S_SAW_0);
    // Accepting one more byte when len already equals MAX_BYTES overflows.
    assign w_len_over = (r_len == MAX_BYTES);
    // Carry out of the 8-bit add is discarded: mod-256 arithmetic.
    assign w_sum_next = r_sum + w_byte;
    // For an ASCII digit the low nibble is already its binary value; 3 digits max 999.
    assign w_val_next = (r_val * 10'd10) + {6'd0, w_byte[3:0]};

    always_comb begin
        if (r_val > 10'd255)
            w_trailer_err = 3'd3;
        else if (r_val[7:0] != r_snap)
            w_trailer_err = 3'd1;
        else
            w_trailer_err = 3'd0;
    end

    always_comb begin
        w_state_next = r_state;
        w_finish     = 1'b0;
        w_fin_err    = 3'd0;
        if (bus.data_valid_i) begin
            if (bus.start_i) begin
                w_state_next = w_is_soh ? S_SAW_SOH : S_BODY;
            end else if (r_state != S_IDLE) begin
                if (w_len_over) begin
                    w_finish  = 1'b1;
                    w_fin_err = 3'd5;
                end else begin
                    case (r_state)
                        S_BODY:    w_state_next = w_is_soh ? S_SAW_SOH : S_BODY;
                        S_SAW_SOH: w_state_next = (w_byte == 8'h31) ? S_SAW_1 :
                                                  w_is_soh ? S_SAW_SOH : S_BODY;
                        S_SAW_1:   w_state_next = (w_byte == 8'h30) ? S_SAW_0 :
                                                  w_is_soh ? S_SAW_SOH : S_BODY;
                        S_SAW_0:   w_state_next = (w_byte == 8'h3D) ? S_DIG0 :
                                                  w_is_soh ? S_SAW_SOH : S_BODY;
                        S_DIG0, S_DIG1, S_DIG2: begin
                            if (w_is_digit) begin
                                w_state_next = r_state + 4'd1;
                            end else begin
                                w_finish  = 1'b1;
                                w_fin_err = 3'd2;
                            end
                        end
                        S_TERM: begin
                            w_finish  = 1'b1;
                            w_fin_err = w_is_soh ? w_trailer_err : 3'd4;
                        end
                        default:   w_state_next = S_IDLE;
                    endcase
                end
            end
        end
        if (w_finish)
            w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_sum   <= 8'd0;
            r_snap  <= 8'd0;
            r_len   <= 16'd0;
            r_val   <= 10'd0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 3'd0;
            r_recv  <= 8'd0;
            r_calc  <= 8'd0;
        end else begin
            r_done  <= w_finish;
            r_state <= w_state_next;
            if (bus.data_valid_i) begin
                if (bus.start_i) begin
                    // New message aborts any message in flight without a verdict.
                    r_sum  <= w_byte;
                    r_snap <= w_is_soh ? w_byte : 8'd0;
                    r_len  <= 16'd1;
                    r_val  <= 10'd0;
                end else if (r_state != S_IDLE && !w_len_over) begin
                    r_len <= r_len + 16'd1;
                    if (w_in_body) begin
                        r_sum <= w_sum_next;
                        if (w_is_soh)
                            r_snap <= w_sum_next;
                        // Entering the digit phase: start decoding from zero.
                        if (r_state == S_SAW_0 && w_byte == 8'h3D)
                            r_val <= 10'd0;
                    end else if ((r_state == S_DIG0 || r_state == S_DIG1 ||
                                  r_state == S_DIG2) && w_is_digit) begin
                        r_val <= w_val_next;
                    end
                end
            end
            if (w_finish) begin
                r_pass <= (w_fin_err == 3'd0);
                r_err  <= w_fin_err;
                r_recv <= r_val[7:0];
                r_calc <= r_snap;
            end
        end
    end

    assign bus.done_o          = r_done;
    assign bus.pass_o          = r_pass;
    assign bus.err_o           = r_err;
    assign bus.recv_checksum_o = r_recv;
    assign bus.calc_checksum_o = r_calc;

endmodule

// File: tb/tb_verify_checksum.sv
// ----------------------------------------------------------------------------
// tb_verify_checksum
// Directed bench for verify_checksum. Two instances share one byte stream:
// u_dut (MAX_BYTES=4096) and u_dut16 (MAX_BYTES=16, used for the overflow
// case). In stimulus strings '|' stands for SOH.
// ----------------------------------------------------------------------------
module tb_verify_checksum;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    verify_checksum_if if1 ();
    verify_checksum_if if2 ();

    verify_checksum u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    verify_checksum #(.MAX_BYTES(16'd16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    int checks = 0;
    int errors = 0;

    int   sel = 0;
    bit   gap_mode = 1'b0;
    int   done_cnt;
    int   done_idx;
    logic cap_pass;
    logic [2:0] cap_err;
    logic [7:0] cap_recv;
    logic [7:0] cap_calc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic v, input logic s);
        if1.data_i = b; if1.data_valid_i = v; if1.start_i = s;
        if2.data_i = b; if2.data_valid_i = v; if2.start_i = s;
    endtask

    task automatic send_byte(input int idx, input logic [7:0] b, input logic s);
        logic d;
        if (gap_mode) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                drive(8'h00, 1'b0, 1'b0);
            end
        end
        @(negedge clk);
        drive(b, 1'b1, s);
        @(posedge clk);
        #1;
        drive(8'h00, 1'b0, 1'b0);
        d = (sel == 0) ? if1.done_o : if2.done_o;
        if (d) begin
            done_cnt++;
            done_idx = idx;
            cap_pass = (sel == 0) ? if1.pass_o : if2.pass_o;
            cap_err  = (sel == 0) ? if1.err_o : if2.err_o;
            cap_recv = (sel == 0) ? if1.recv_checksum_o : if2.recv_checksum_o;
            cap_calc = (sel == 0) ? if1.calc_checksum_o : if2.calc_checksum_o;
        end
    endtask

    task automatic send_str(input string str, input bit with_start);
        logic [7:0] b;
        done_cnt = 0;
        done_idx = -1;
        for (int i = 0; i < str.len(); i++) begin
            b = str[i];
            if (b == 8'h7C) b = 8'h01;
            send_byte(i, b, with_start && (i == 0));
        end
        $display("msg \"%s\" done_cnt=%0d done_idx=%0d pass=%0d err=%0d recv=%02h calc=%02h",
                 str, done_cnt, done_idx, cap_pass, cap_err, cap_recv, cap_calc);
    endtask

    initial begin
        drive(8'h00, 1'b0, 1'b0);
        cap_pass = 1'b0; cap_err = 3'd0; cap_recv = 8'd0; cap_calc = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 32'(if1.done_o), 32'd0);
        check("rst_pass", 32'(if1.pass_o), 32'd0);
        check("rst_err",  32'(if1.err_o), 32'd0);
        check("rst_recv", 32'(if1.recv_checksum_o), 32'd0);
        check("rst_calc", 32'(if1.calc_checksum_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // 56+61+65+1 = 183
        send_str("8=A|10=183|", 1'b1);
        check("m1_cnt",  32'(done_cnt), 32'd1);
        check("m1_idx",  32'(done_idx), 32'd10);
        check("m1_pass", 32'(cap_pass), 32'd1);
        check("m1_err",  32'(cap_err), 32'd0);
        check("m1_calc", 32'(cap_calc), 32'hB7);
        check("m1_recv", 32'(cap_recv), 32'hB7);

        // 316 mod 256 = 60
        send_str("8=ABC|10=060|", 1'b1);
        check("m2_pass", 32'(cap_pass), 32'd1);
        check("m2_calc", 32'(cap_calc), 32'h3C);
        check("m2_err",  32'(cap_err), 32'd0);

        send_str("8=ABC|10=061|", 1'b1);
        check("m2b_pass", 32'(cap_pass), 32'd0);
        check("m2b_err",  32'(cap_err), 32'd1);
        check("m2b_recv", 32'(cap_recv), 32'h3D);
        check("m2b_calc", 32'(cap_calc), 32'h3C);

        send_str("8=A|10=1A3", 1'b1);
        check("nd_cnt", 32'(done_cnt), 32'd1);
        check("nd_idx", 32'(done_idx), 32'd8);
        check("nd_err", 32'(cap_err), 32'd2);

        send_str("8=A|10=300|", 1'b1);
        check("big_err",  32'(cap_err), 32'd3);
        check("big_recv", 32'(cap_recv), 32'h2C);
        check("big_pass", 32'(cap_pass), 32'd0);

        send_str("8=A|10=183X", 1'b1);
        check("term_idx", 32'(done_idx), 32'd10);
        check("term_err", 32'(cap_err), 32'd4);

        // Verdict holds while idle; done is a single pulse.
        repeat (3) @(posedge clk);
        #1;
        check("hold_done", 32'(if1.done_o), 32'd0);
        check("hold_err",  32'(if1.err_o), 32'd4);

        // 183 + "110=5" + SOH = 444 -> 188
        send_str("8=A|110=5|10=188|", 1'b1);
        check("tag_cnt",  32'(done_cnt), 32'd1);
        check("tag_pass", 32'(cap_pass), 32'd1);
        check("tag_calc", 32'(cap_calc), 32'hBC);

        gap_mode = 1'b1;
        send_str("8=A|110=5|10=188|", 1'b1);
        gap_mode = 1'b0;
        check("gap_idx",  32'(done_idx), 32'd16);
        check("gap_pass", 32'(cap_pass), 32'd1);
        check("gap_calc", 32'(cap_calc), 32'hBC);

        send_str("8=AB", 1'b1);
        check("abort_cnt", 32'(done_cnt), 32'd0);
        send_str("8=A|10=183|", 1'b1);
        check("abort_new_cnt",  32'(done_cnt), 32'd1);
        check("abort_new_pass", 32'(cap_pass), 32'd1);

        // Overflow on the MAX_BYTES=16 instance: 17th byte overflows.
        sel = 1;
        send_str("8=XXXXXXXXXXXXXXXXXXXX", 1'b1);
        check("ovf_cnt", 32'(done_cnt), 32'd1);
        check("ovf_idx", 32'(done_idx), 32'd16);
        check("ovf_err", 32'(cap_err), 32'd5);
        sel = 0;

        // Async reset while in DIG1.
        send_str("8=A|10=1", 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_pass", 32'(if1.pass_o), 32'd0);
        check("arst_calc", 32'(if1.calc_checksum_o), 32'd0);
        check("arst_recv", 32'(if1.recv_checksum_o), 32'd0);
        check("arst_err",  32'(if1.err_o), 32'd0);
        check("arst_done", 32'(if1.done_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        send_str("10=183|", 1'b0);
        check("arst_stale", 32'(done_cnt), 32'd0);
        send_str("8=A|10=183|", 1'b1);
        check("arst_fresh_cnt",  32'(done_cnt), 32'd1);
        check("arst_fresh_pass", 32'(cap_pass), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
